// File: rtl/matrix_index_counter_pkg.sv
// Shared definitions for the row-major matrix index counter: state encoding and default widths.
package matrix_index_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MI_ROW_W = 10;
    localparam int MI_COL_W = 10;

endpackage

// File: rtl/matrix_index_counter_if.sv
// Control/index bundle between the matrix controller (master) and the index counter (slave).
// Optional addr signal present only when MATRIX_INDEX_ADDR_EN is defined.
interface matrix_index_counter_if
    import matrix_index_pkg::*;
#(
    parameter int ROW_W = MI_ROW_W,
    parameter int COL_W = MI_COL_W
);

    logic             start;
    logic [ROW_W-1:0] num_rows;
    logic [COL_W-1:0] num_cols;
    logic             step;
    logic             clear;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             busy;
    logic             last;
    logic             done;
`ifdef MATRIX_INDEX_ADDR_EN
    logic [ROW_W+COL_W-1:0] addr;
`endif

    modport master (
        output start, num_rows, num_cols, step, clear,
        input  row, col, busy, last, done
`ifdef MATRIX_INDEX_ADDR_EN
        , input addr
`endif
    );

    modport slave (
        input  start, num_rows, num_cols, step, clear,
        output row, col, busy, last, done
`ifdef MATRIX_INDEX_ADDR_EN
        , output addr
`endif
    );

endinterface

// File: rtl/matrix_index_counter.sv
// Row-major 2-D index counter with start/done handshake, synchronous clear and last flag.
// Define MATRIX_INDEX_ADDR_EN to add a linear addr output maintained without a multiplier.
module matrix_index_counter
    import matrix_index_pkg::*;
#(
    parameter int ROW_W = MI_ROW_W,
    parameter int COL_W = MI_COL_W
) (
    input  logic                  clk,
    input  logic                  reset,
    matrix_index_counter_if.slave bus
);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] rows_q, rows_d;
    logic [COL_W-1:0] cols_q, cols_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef MATRIX_INDEX_ADDR_EN
    logic [ROW_W+COL_W-1:0] addr_q, addr_d;
`endif

    logic row_end;
    logic col_end;
    logic last_w;

    // Limits are compared only against the latched copies, never the live inputs.
    assign row_end = (row_q == rows_q - ROW_W'(1));
    assign col_end = (col_q == cols_q - COL_W'(1));
    assign last_w  = busy_q && row_end && col_end;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MATRIX_INDEX_ADDR_EN
        addr_d  = addr_q;
`endif

        if (bus.clear) begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
            busy_d  = 1'b0;
`ifdef MATRIX_INDEX_ADDR_EN
            addr_d  = '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.num_rows != '0 && bus.num_cols != '0) begin
                            rows_d  = bus.num_rows;
                            cols_d  = bus.num_cols;
                            row_d   = '0;
                            col_d   = '0;
                            busy_d  = 1'b1;
                            state_d = ST_RUN;
`ifdef MATRIX_INDEX_ADDR_EN
                            addr_d  = '0;
`endif
                        end else begin
                            // Empty matrix: report completion without ever going busy.
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end

                ST_RUN: begin
                    if (bus.step) begin
                        if (last_w) begin
                            row_d   = '0;
                            col_d   = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
`ifdef MATRIX_INDEX_ADDR_EN
                            addr_d  = '0;
`endif
                        end else begin
                            if (col_end) begin
                                col_d = '0;
                                row_d = row_q + ROW_W'(1);
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
`ifdef MATRIX_INDEX_ADDR_EN
                            addr_d = addr_q + (ROW_W+COL_W)'(1);
`endif
                        end
                    end
                end

                ST_DONE: state_d = ST_IDLE;

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MATRIX_INDEX_ADDR_EN
            addr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MATRIX_INDEX_ADDR_EN
            addr_q  <= addr_d;
`endif
        end
    end

    assign bus.row  = row_q;
    assign bus.col  = col_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.last = last_w;
`ifdef MATRIX_INDEX_ADDR_EN
    assign bus.addr = addr_q;
`endif

endmodule
